// File: rtl/tug_game_controller_pkg.sv
// Shared definitions for the tug-of-war game controller: game states,
// winner codes, small constants and the question answer table.
package tug_game_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAY      = 2'd2,
    ST_WIN       = 2'd3
  } game_state_t;

  localparam logic [1:0] WINNER_NONE = 2'd0;
  localparam logic [1:0] WINNER_P1   = 2'd1;
  localparam logic [1:0] WINNER_P2   = 2'd2;

  localparam logic [3:0] LAST_QUESTION   = 4'd9;
  localparam logic [3:0] MAX_DIGIT       = 4'd9;
  localparam logic [3:0] COUNTDOWN_START = 4'd3;

  // Expected answer (A+B) for each question index; out-of-range indices give 0.
  function automatic logic [3:0] tug_answer(input logic [3:0] q);
    logic [3:0] a;
    case (q)
      4'd0:    a = 4'd3;
      4'd1:    a = 4'd7;
      4'd2:    a = 4'd5;
      4'd3:    a = 4'd9;
      4'd4:    a = 4'd15;
      4'd5:    a = 4'd8;
      4'd6:    a = 4'd12;
      4'd7:    a = 4'd7;
      4'd8:    a = 4'd14;
      4'd9:    a = 4'd15;
      default: a = 4'd0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/tug_game_controller_tick_counter.sv
// Down-counter used for the countdown steps and the per-player lockout.
// Loading sets it to CYCLES; it then counts down to zero while enabled.
// o_busy is high while the count is non-zero, o_done pulses for the one
// enabled cycle in which the count steps from 1 to 0.
module tug_tick_counter #(
  parameter int CYCLES = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_load,
  input  logic i_enable,
  output logic o_busy,
  output logic o_done
);

  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES);
  localparam logic [W-1:0] ONE      = W'(1);

  logic [W-1:0] r_count;

  // Load wins over clear so a restart issued from another state is not lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

  assign o_busy = (r_count != '0);
  assign o_done = i_enable && (r_count == ONE);

endmodule

// File: rtl/tug_game_controller.sv
// Game-flow controller for the two-player arithmetic tug-of-war.
// IDLE -> 3-2-1 countdown -> PLAY -> WIN, with answer checking, rope
// movement and a lockout for a player who submits a wrong answer.
// Every output is a register, updated one clock after the input pulse.
module tug_game_controller
  import tug_game_controller_pkg::*;
#(
  parameter int TICK_CYCLES    = 100_000_000,
  parameter int PENALTY_CYCLES = 50_000_000,
  parameter int ROPE_CENTER    = 320,
  parameter int ROPE_STEP      = 32,
  parameter int WIN_LEFT       = 160,
  parameter int WIN_RIGHT      = 480
) (
  input  logic       clk_100mhz,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       p1_key_valid,
  input  logic [3:0] p1_key,
  input  logic       p1_enter,
  input  logic       p2_key_valid,
  input  logic [3:0] p2_key,
  input  logic       p2_enter,
  output logic [3:0] q_id,
  output logic [3:0] p1_val,
  output logic [3:0] p2_val,
  output logic [9:0] rope_x,
  output logic [1:0] winner_code,
  output logic       is_idle,
  output logic       is_countdown,
  output logic [3:0] countdown_val
);

  localparam logic [9:0]        CENTER10 = 10'(ROPE_CENTER);
  localparam logic [9:0]        LEFT10   = 10'(WIN_LEFT);
  localparam logic [9:0]        RIGHT10  = 10'(WIN_RIGHT);
  localparam logic signed [10:0] STEP11  = 11'(ROPE_STEP);
  localparam logic signed [10:0] LEFT11  = 11'(WIN_LEFT);
  localparam logic signed [10:0] RIGHT11 = 11'(WIN_RIGHT);

  game_state_t r_state;
  logic [3:0]  r_q_id;
  logic [3:0]  r_p1_val;
  logic [3:0]  r_p2_val;
  logic [9:0]  r_rope_x;
  logic [1:0]  r_winner;
  logic        r_is_idle;
  logic        r_is_cd;
  logic [3:0]  r_cd_val;

  logic        w_in_play;
  logic [3:0]  w_answer;
  logic        w_cd_tick, w_cd_busy, w_cd_load, w_cd_clear;
  logic        w_p1_locked, w_p2_locked, w_p1_done, w_p2_done;
  logic        w_p1_enter, w_p2_enter;
  logic        w_p1_correct, w_p2_correct, w_any_correct;
  logic        w_p1_wrong, w_p2_wrong;
  logic        w_p1_key_ok, w_p2_key_ok;
  logic [3:0]  w_p1_key_val, w_p2_key_val;
  logic [3:0]  w_q_next;
  logic signed [10:0] w_rope_next;
  logic        w_hit_left, w_hit_right;
  logic        w_unused_ok;

  assign w_in_play = (r_state == ST_PLAY);
  assign w_answer  = tug_answer(r_q_id);

  // Countdown steps restart on game start and after every non-final tick.
  assign w_cd_load  = ((r_state == ST_IDLE) && btn_start) ||
                      ((r_state == ST_COUNTDOWN) && w_cd_tick && (r_cd_val != 4'd1));
  assign w_cd_clear = (r_state != ST_COUNTDOWN);

  tug_tick_counter #(.CYCLES(TICK_CYCLES)) u_countdown_tick (
    .i_clk    (clk_100mhz),
    .i_rst_n  (reset),
    .i_clear  (w_cd_clear),
    .i_load   (w_cd_load),
    .i_enable (r_state == ST_COUNTDOWN),
    .o_busy   (w_cd_busy),
    .o_done   (w_cd_tick)
  );

  tug_tick_counter #(.CYCLES(PENALTY_CYCLES)) u_p1_penalty (
    .i_clk    (clk_100mhz),
    .i_rst_n  (reset),
    .i_clear  (!w_in_play),
    .i_load   (w_p1_wrong),
    .i_enable (1'b1),
    .o_busy   (w_p1_locked),
    .o_done   (w_p1_done)
  );

  tug_tick_counter #(.CYCLES(PENALTY_CYCLES)) u_p2_penalty (
    .i_clk    (clk_100mhz),
    .i_rst_n  (reset),
    .i_clear  (!w_in_play),
    .i_load   (w_p2_wrong),
    .i_enable (1'b1),
    .o_busy   (w_p2_locked),
    .o_done   (w_p2_done)
  );

  assign w_unused_ok = w_cd_busy ^ w_p1_done ^ w_p2_done;

  // An enter is only honoured in PLAY and outside a lockout; it judges the value already held.
  assign w_p1_enter    = w_in_play && p1_enter && !w_p1_locked;
  assign w_p2_enter    = w_in_play && p2_enter && !w_p2_locked;
  assign w_p1_correct  = w_p1_enter && (r_p1_val == w_answer);
  assign w_p2_correct  = w_p2_enter && (r_p2_val == w_answer);
  assign w_p1_wrong    = w_p1_enter && (r_p1_val != w_answer);
  assign w_p2_wrong    = w_p2_enter && (r_p2_val != w_answer);
  assign w_any_correct = w_p1_correct || w_p2_correct;

  // A digit is dropped when the same player also pressed enter this cycle.
  assign w_p1_key_ok  = p1_key_valid && !p1_enter && !w_p1_locked && (p1_key <= MAX_DIGIT);
  assign w_p2_key_ok  = p2_key_valid && !p2_enter && !w_p2_locked && (p2_key <= MAX_DIGIT);
  assign w_p1_key_val = ((r_p1_val == 4'd1) && (p1_key <= 4'd5)) ? (p1_key + 4'd10) : p1_key;
  assign w_p2_key_val = ((r_p2_val == 4'd1) && (p2_key <= 4'd5)) ? (p2_key + 4'd10) : p2_key;

  assign w_q_next = (r_q_id == LAST_QUESTION) ? 4'd0 : (r_q_id + 4'd1);

  // Candidate rope position in 11-bit signed so a pull past zero cannot wrap.
  always_comb begin
    w_rope_next = $signed({1'b0, r_rope_x});
    if (w_p1_correct && !w_p2_correct) begin
      w_rope_next = w_rope_next - STEP11;
    end else if (w_p2_correct && !w_p1_correct) begin
      w_rope_next = w_rope_next + STEP11;
    end
  end

  assign w_hit_left  = (w_rope_next <= LEFT11);
  assign w_hit_right = (w_rope_next >= RIGHT11);

  // Game state machine with all display-facing outputs registered.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_q_id    <= 4'd0;
      r_p1_val  <= 4'd0;
      r_p2_val  <= 4'd0;
      r_rope_x  <= CENTER10;
      r_winner  <= WINNER_NONE;
      r_is_idle <= 1'b1;
      r_is_cd   <= 1'b0;
      r_cd_val  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (btn_start) begin
            r_state   <= ST_COUNTDOWN;
            r_is_idle <= 1'b0;
            r_is_cd   <= 1'b1;
            r_cd_val  <= COUNTDOWN_START;
          end
        end
        ST_COUNTDOWN: begin
          if (w_cd_tick) begin
            if (r_cd_val == 4'd1) begin
              r_state  <= ST_PLAY;
              r_is_cd  <= 1'b0;
              r_cd_val <= 4'd0;
              r_q_id   <= 4'd0;
              r_p1_val <= 4'd0;
              r_p2_val <= 4'd0;
              r_rope_x <= CENTER10;
            end else begin
              r_cd_val <= r_cd_val - 4'd1;
            end
          end
        end
        ST_PLAY: begin
          if (w_any_correct) begin
            r_q_id   <= w_q_next;
            r_p1_val <= 4'd0;
            r_p2_val <= 4'd0;
          end else begin
            if (w_p1_wrong) begin
              r_p1_val <= 4'd0;
            end else if (w_p1_key_ok) begin
              r_p1_val <= w_p1_key_val;
            end
            if (w_p2_wrong) begin
              r_p2_val <= 4'd0;
            end else if (w_p2_key_ok) begin
              r_p2_val <= w_p2_key_val;
            end
          end
          if (w_hit_left) begin
            r_rope_x <= LEFT10;
            r_winner <= WINNER_P1;
            r_state  <= ST_WIN;
          end else if (w_hit_right) begin
            r_rope_x <= RIGHT10;
            r_winner <= WINNER_P2;
            r_state  <= ST_WIN;
          end else begin
            r_rope_x <= w_rope_next[9:0];
          end
        end
        ST_WIN: begin
          if (btn_start) begin
            r_state   <= ST_IDLE;
            r_is_idle <= 1'b1;
            r_winner  <= WINNER_NONE;
            r_rope_x  <= CENTER10;
            r_p1_val  <= 4'd0;
            r_p2_val  <= 4'd0;
            r_q_id    <= 4'd0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign q_id          = r_q_id;
  assign p1_val        = r_p1_val;
  assign p2_val        = r_p2_val;
  assign rope_x        = r_rope_x;
  assign winner_code   = r_winner;
  assign is_idle       = r_is_idle;
  assign is_countdown  = r_is_cd;
  assign countdown_val = r_cd_val;

endmodule

// File: tb/tb_tug_game_controller.sv
// Scoreboard bench for tug_game_controller. Each driven cycle advances a
// game-rules reference model and queues the outputs expected after the
// next clock edge; an independent monitor pops and compares them.
module tb_tug_game_controller;

  localparam int TICK    = 10;
  localparam int PENALTY = 5;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] v1;
    logic [3:0] v2;
    logic [9:0] rope;
    logic [1:0] win;
    logic       idle;
    logic       cd;
    logic [3:0] cdv;
  } obs_t;

  logic       clk = 1'b0;
  logic       resetN;
  logic       btnStart;
  logic       p1KeyValid, p1Enter, p2KeyValid, p2Enter;
  logic [3:0] p1Key, p2Key;
  logic [3:0] qId, p1Val, p2Val, cdVal;
  logic [9:0] ropeX;
  logic [1:0] winnerCode;
  logic       isIdle, isCountdown;

  obs_t expQ[$];
  int   nCompared = 0;
  int   nMismatched = 0;

  // Reference model state: game phase 0 idle, 1 countdown, 2 play, 3 win.
  int ANS[10] = '{3, 7, 5, 9, 15, 8, 12, 7, 14, 15};
  int mPhase, mQ, mRope, mWin, mCd, mCdStart, mEdge;
  int mV[2];
  int mLockUntil[2];

  tug_game_controller #(
    .TICK_CYCLES(TICK), .PENALTY_CYCLES(PENALTY), .ROPE_CENTER(320),
    .ROPE_STEP(32), .WIN_LEFT(160), .WIN_RIGHT(480)
  ) dut (
    .clk_100mhz(clk), .reset(resetN), .btn_start(btnStart),
    .p1_key_valid(p1KeyValid), .p1_key(p1Key), .p1_enter(p1Enter),
    .p2_key_valid(p2KeyValid), .p2_key(p2Key), .p2_enter(p2Enter),
    .q_id(qId), .p1_val(p1Val), .p2_val(p2Val), .rope_x(ropeX),
    .winner_code(winnerCode), .is_idle(isIdle), .is_countdown(isCountdown),
    .countdown_val(cdVal)
  );

  always #5 clk = ~clk;

  function automatic obs_t modelObs();
    obs_t o;
    o.q    = 4'(mQ);
    o.v1   = 4'(mV[0]);
    o.v2   = 4'(mV[1]);
    o.rope = 10'(mRope);
    o.win  = 2'(mWin);
    o.idle = (mPhase == 0);
    o.cd   = (mPhase == 1);
    o.cdv  = 4'(mCd);
    return o;
  endfunction

  function automatic obs_t actualObs();
    obs_t o;
    o = '{qId, p1Val, p2Val, ropeX, winnerCode, isIdle, isCountdown, cdVal};
    return o;
  endfunction

  task automatic modelReset();
    mPhase = 0; mQ = 0; mRope = 320; mWin = 0; mCd = 0; mCdStart = 0;
    mV[0] = 0; mV[1] = 0;
    mLockUntil[0] = -1; mLockUntil[1] = -1;
  endtask

  // One clock edge of the game rules, driven by the inputs present at that edge.
  task automatic modelStep(input bit st, input bit k1v, input int k1, input bit e1,
                           input bit k2v, input int k2, input bit e2);
    bit kv[2], en[2], lk[2], ent[2], cor[2], wr[2];
    int k[2];
    int ans;
    mEdge++;
    kv[0] = k1v; kv[1] = k2v; k[0] = k1; k[1] = k2; en[0] = e1; en[1] = e2;
    case (mPhase)
      0: if (st) begin mPhase = 1; mCd = 3; mCdStart = mEdge; end
      1: if (((mEdge - mCdStart) % TICK) == 0) begin
           if (mCd == 1) begin
             mPhase = 2; mCd = 0; mQ = 0; mV[0] = 0; mV[1] = 0; mRope = 320;
           end else begin
             mCd--;
           end
         end
      2: begin
           ans = ANS[mQ];
           for (int p = 0; p < 2; p++) begin
             lk[p]  = (mEdge <= mLockUntil[p]);
             ent[p] = en[p] && !lk[p];
             cor[p] = ent[p] && (mV[p] == ans);
             wr[p]  = ent[p] && (mV[p] != ans);
           end
           if (cor[0] || cor[1]) begin
             mRope = mRope + 32 * (int'(cor[1]) - int'(cor[0]));
             mQ = (mQ + 1) % 10;
             mV[0] = 0; mV[1] = 0;
           end else begin
             for (int p = 0; p < 2; p++) begin
               if (wr[p]) mV[p] = 0;
               else if (kv[p] && !lk[p] && !en[p] && k[p] <= 9)
                 mV[p] = (mV[p] == 1 && k[p] <= 5) ? 10 + k[p] : k[p];
             end
           end
           for (int p = 0; p < 2; p++) if (wr[p]) mLockUntil[p] = mEdge + PENALTY;
           if (mRope <= 160) begin
             mRope = 160; mWin = 1; mPhase = 3;
             mLockUntil[0] = -1; mLockUntil[1] = -1;
           end else if (mRope >= 480) begin
             mRope = 480; mWin = 2; mPhase = 3;
             mLockUntil[0] = -1; mLockUntil[1] = -1;
           end
         end
      default: if (st) begin
           mPhase = 0; mWin = 0; mRope = 320; mV[0] = 0; mV[1] = 0; mQ = 0;
         end
    endcase
  endtask

  task automatic applyStimulus(input bit st, input bit k1v, input int k1, input bit e1,
                               input bit k2v, input int k2, input bit e2);
    @(negedge clk);
    btnStart = st;
    p1KeyValid = k1v; p1Key = 4'(k1); p1Enter = e1;
    p2KeyValid = k2v; p2Key = 4'(k2); p2Enter = e2;
    modelStep(st, k1v, k1, e1, k2v, k2, e2);
    expQ.push_back(modelObs());
  endtask

  task automatic checkOutput(input string name, input obs_t want);
    obs_t got;
    got = actualObs();
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic press(input int p, input int k);
    if (p == 0) applyStimulus(0, 1, k, 0, 0, 0, 0);
    else        applyStimulus(0, 0, 0, 0, 1, k, 0);
  endtask

  task automatic pressEnter(input int p);
    if (p == 0) applyStimulus(0, 0, 0, 1, 0, 0, 0);
    else        applyStimulus(0, 0, 0, 0, 0, 0, 1);
  endtask

  // Key in the current question's answer for player p, then submit it.
  task automatic answerCorrect(input int p);
    int a;
    a = ANS[mQ];
    if (a >= 10) begin
      if (mV[p] != 1) press(p, 1);
      press(p, a - 10);
    end else begin
      press(p, a);
    end
    pressEnter(p);
  endtask

  task automatic startGame();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    idleCycles(3 * TICK + 1);
  endtask

  // Monitor: every output update announced by the driver is checked here.
  initial begin
    obs_t want, got;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        want = expQ.pop_front();
        got  = actualObs();
        nCompared++;
        if (got !== want) begin
          nMismatched++;
          $display("[TB] FAIL scoreboard t=%0t got q=%0d v1=%0d v2=%0d rope=%0d win=%0d idle=%0b cd=%0b cdv=%0d expected q=%0d v1=%0d v2=%0d rope=%0d win=%0d idle=%0b cd=%0b cdv=%0d",
                   $time, got.q, got.v1, got.v2, got.rope, got.win, got.idle, got.cd, got.cdv,
                   want.q, want.v1, want.v2, want.rope, want.win, want.idle, want.cd, want.cdv);
        end
      end
    end
  end

  initial begin
    obs_t resetObs;
    int r, a, st;
    bit kv[2], en[2];
    int k[2];
    resetObs = '{4'd0, 4'd0, 4'd0, 10'd320, 2'd0, 1'b1, 1'b0, 4'd0};
    mEdge = 0;
    modelReset();
    resetN = 1'b0; btnStart = 1'b0;
    p1KeyValid = 1'b0; p1Key = 4'd0; p1Enter = 1'b0;
    p2KeyValid = 1'b0; p2Key = 4'd0; p2Enter = 1'b0;
    #12;
    checkOutput("power_on_reset", resetObs);
    @(negedge clk);
    resetN = 1'b1;

    // Play into a game and pull the rope to 256, then reset mid-play.
    idleCycles(2);
    startGame();
    answerCorrect(0);
    answerCorrect(0);
    @(posedge clk);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("async_reset_mid_play", resetObs);
    modelReset();
    @(negedge clk);
    resetN = 1'b1;

    // Countdown then the scripted answer sequence.
    startGame();
    answerCorrect(0);
    press(1, 1);
    press(1, 5);
    press(1, 4);
    pressEnter(1);
    applyStimulus(0, 1, 7, 0, 1, 5, 0);
    applyStimulus(0, 0, 0, 1, 1, 5, 0);
    for (int i = 0; i < 3; i++) press(1, 5);
    press(1, 5);
    press(0, 5);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 7; i++) answerCorrect((mQ % 2 == 0) ? 0 : 1);
    while (mPhase == 2) answerCorrect(0);
    applyStimulus(0, 1, 3, 1, 1, 7, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    startGame();
    for (int i = 0; i < 5; i++) answerCorrect(0);
    applyStimulus(0, 1, 2, 0, 1, 9, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    idleCycles(2);

    // Randomised play, steering keys toward the right answer most of the time.
    for (int c = 0; c < 3000; c++) begin
      st = ($urandom_range(0, 29) == 0) ? 1 : 0;
      a = ANS[mQ];
      for (int p = 0; p < 2; p++) begin
        r = $urandom_range(0, 9);
        kv[p] = 0; k[p] = 0; en[p] = 0;
        if (r >= 3 && r < 6) begin
          kv[p] = 1;
          k[p] = (a < 10) ? a : ((mV[p] == 1) ? a - 10 : 1);
        end else if (r == 6 || r == 7) begin
          en[p] = 1;
        end else if (r >= 8) begin
          kv[p] = 1;
          k[p] = $urandom_range(0, 15);
          if (r == 9) en[p] = ($urandom_range(0, 1) == 1);
        end
      end
      applyStimulus(st[0], kv[0], k[0], en[0], kv[1], k[1], en[1]);
    end

    @(posedge clk);
    #3;
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL scoreboard_drain got=%0d pending expected=0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
